// File: rtl/mips_mem_stage_hs.sv
// mips_mem_stage_hs: MIPS MEM stage issuing its own variable-latency data-bus access
module mips_mem_stage_hs #(
  parameter int OP_W          = 32,
  parameter int RF_AW         = 5,
  parameter bit HAS_UNALIGNED = 1,
  parameter bit ADDR_CHECK    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_ready_go,
  output logic             mem_allowin,
  input  logic [OP_W-1:0]  ex_op,
  input  logic [3:0]       ex_mem_ctrl,
  input  logic [RF_AW-1:0] ex_rf_waddr,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_rt_data,
  input  logic [31:0]      ex_pc,
  input  logic             flush,
  output logic             data_req,
  output logic             data_wr,
  output logic [1:0]       data_size,
  output logic [31:0]      data_addr,
  output logic [3:0]       data_wstrb,
  output logic [31:0]      data_wdata,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  input  logic [31:0]      data_rdata,
  output logic             mem_valid,
  output logic             mem_valid_ready_go,
  input  logic             wb_allowin,
  output logic [OP_W-1:0]  mem_out_op,
  output logic [RF_AW-1:0] mem_rf_waddr,
  output logic [31:0]      mem_out_value,
  output logic [31:0]      mem_pc,
  output logic             mem_excp,
  output logic [4:0]       mem_excp_code,
  output logic [31:0]      mem_badvaddr,
  output logic             mem_load_pending
);
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3,
                         S_DROP_REQ = 3'd4, S_DROP_DATA = 3'd5;
  localparam logic [3:0] C_LB = 4'd1, C_LBU = 4'd2, C_LH = 4'd3, C_LHU = 4'd4, C_LW = 4'd5,
                         C_LWL = 4'd6, C_LWR = 4'd7, C_SB = 4'd9, C_SH = 4'd10, C_SW = 4'd11,
                         C_SWL = 4'd12, C_SWR = 4'd13;
  function automatic logic unal_op(input logic [3:0] c);
    return c == C_LWL || c == C_LWR || c == C_SWL || c == C_SWR;
  endfunction
  function automatic logic [3:0] norm(input logic [3:0] c);
    return ((c >= C_LB && c <= C_LWR) || (c >= C_SB && c <= C_SWR)) && (HAS_UNALIGNED || !unal_op(c)) ? c : 4'd0;
  endfunction
  function automatic logic adr_err(input logic [3:0] c, input logic [1:0] a);
    return ADDR_CHECK && (((c == C_LH || c == C_LHU || c == C_SH) && a[0]) ||
                          ((c == C_LW || c == C_SW) && a != 2'b00));
  endfunction
  logic [2:0]       state, state_n;
  logic [OP_W-1:0]  op_r;
  logic [RF_AW-1:0] waddr_r;
  logic [31:0]      addr_r, rt_r, pc_r, rdata_r;
  logic [3:0]       ctrl_r, ex_c;
  logic             excp_r, ready_go, accept, is_load, is_store;
  logic [1:0]       a;
  logic [7:0]       lb;
  logic [15:0]      lh;
  logic [31:0]      lwl, lwr, load_val;
  assign ex_c     = norm(ex_mem_ctrl);
  assign a        = addr_r[1:0];
  assign is_load  = ctrl_r != 4'd0 && ctrl_r <= C_LWR;
  assign is_store = ctrl_r >= C_SB;
  assign ready_go = state == S_DONE || (state == S_IDLE && mem_valid);
  assign mem_allowin = state != S_DROP_REQ && state != S_DROP_DATA && (!mem_valid || (ready_go && wb_allowin));
  assign accept   = ex_valid_ready_go && mem_allowin && !flush;
  assign data_req  = state == S_REQ || state == S_DROP_REQ;
  assign data_wr   = is_store;
  assign data_size = (ctrl_r == C_LB || ctrl_r == C_LBU || ctrl_r == C_SB) ? 2'd0 :
                     (ctrl_r == C_LH || ctrl_r == C_LHU || ctrl_r == C_SH) ? 2'd1 : 2'd2;
  assign data_addr = unal_op(ctrl_r) ? {addr_r[31:2], 2'b00} : addr_r;
  // Store strobes and lane-replicated/shifted store data, held from the latched instruction
  always_comb begin
    data_wstrb = ctrl_r == C_SB  ? 4'b0001 << a :
                 ctrl_r == C_SH  ? (a[1] ? 4'b1100 : 4'b0011) :
                 ctrl_r == C_SW  ? 4'b1111 :
                 ctrl_r == C_SWL ? 4'b1111 >> ~a :
                 ctrl_r == C_SWR ? 4'b1111 << a : 4'b0000;
    data_wdata = ctrl_r == C_SB  ? {4{rt_r[7:0]}} :
                 ctrl_r == C_SH  ? {2{rt_r[15:0]}} :
                 ctrl_r == C_SWL ? rt_r >> {~a, 3'b000} :
                 ctrl_r == C_SWR ? rt_r << {a, 3'b000} : rt_r;
  end
  assign lb  = 8'(rdata_r >> {a, 3'b000});
  assign lh  = a[1] ? rdata_r[31:16] : rdata_r[15:0];
  assign lwl = (rdata_r << {~a, 3'b000}) | (rt_r & ~(32'hFFFF_FFFF << {~a, 3'b000}));
  assign lwr = (rdata_r >> {a, 3'b000}) | (rt_r & ~(32'hFFFF_FFFF >> {a, 3'b000}));
  // Lane extraction and LWL/LWR merge of the captured read data
  always_comb begin
    load_val = ctrl_r == C_LB  ? {{24{lb[7]}}, lb} :
               ctrl_r == C_LBU ? {24'd0, lb} :
               ctrl_r == C_LH  ? {{16{lh[15]}}, lh} :
               ctrl_r == C_LHU ? {16'd0, lh} :
               ctrl_r == C_LWL ? lwl :
               ctrl_r == C_LWR ? lwr : rdata_r;
  end
  assign mem_out_value      = (is_load && !excp_r) ? load_val : addr_r;
  assign mem_valid_ready_go = mem_valid && ready_go;
  assign mem_load_pending   = mem_valid && is_load && !ready_go;
  assign mem_excp           = mem_valid && excp_r;
  assign mem_excp_code      = is_store ? 5'd5 : 5'd4;
  assign mem_badvaddr       = addr_r;
  assign mem_out_op         = op_r;
  assign mem_rf_waddr       = waddr_r;
  assign mem_pc             = pc_r;
  // Bus FSM; flushed transactions drain through the DROP states so no response is orphaned
  always_comb begin
    state_n = state;
    case (state)
      S_REQ:       state_n = flush ? (data_addr_ok ? S_DROP_DATA : S_DROP_REQ) : (data_addr_ok ? S_WAIT : S_REQ);
      S_WAIT:      state_n = data_data_ok ? (flush ? S_IDLE : S_DONE) : (flush ? S_DROP_DATA : S_WAIT);
      S_DROP_REQ:  state_n = data_addr_ok ? S_DROP_DATA : S_DROP_REQ;
      S_DROP_DATA: state_n = data_data_ok ? S_IDLE : S_DROP_DATA;
      default:     state_n = accept ? ((ex_c != 4'd0 && !adr_err(ex_c, ex_addr[1:0])) ? S_REQ : S_IDLE) :
                             (flush || mem_allowin) ? S_IDLE : state;
    endcase
  end
  // Pipeline register, instruction latch and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_valid <= 1'b0;
      op_r      <= '0;
      waddr_r   <= '0;
      addr_r    <= '0;
      rt_r      <= '0;
      pc_r      <= '0;
      ctrl_r    <= '0;
      excp_r    <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state     <= state_n;
      mem_valid <= flush ? 1'b0 : mem_allowin ? ex_valid_ready_go : mem_valid;
      if (accept) begin
        op_r    <= ex_op;
        waddr_r <= ex_rf_waddr;
        addr_r  <= ex_addr;
        rt_r    <= ex_rt_data;
        pc_r    <= ex_pc;
        ctrl_r  <= ex_c;
        excp_r  <= ex_c != 4'd0 && adr_err(ex_c, ex_addr[1:0]);
      end
      if (state == S_WAIT && data_data_ok) rdata_r <= data_rdata;
    end
  end
endmodule

// File: tb/tb_mips_mem_stage_hs.sv
// tb_mips_mem_stage_hs: directed plus randomized check of the MEM stage against a transaction-level model
module tb_mips_mem_stage_hs;
  localparam int OP_W = 32, RF_AW = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid_ready_go = 1'b0, flush = 1'b0, wb_allowin = 1'b1;
  logic [OP_W-1:0] ex_op = '0;
  logic [3:0] ex_mem_ctrl = '0;
  logic [RF_AW-1:0] ex_rf_waddr = '0;
  logic [31:0] ex_addr = '0, ex_rt_data = '0, ex_pc = '0, data_rdata = '0;
  logic data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic mem_allowin, data_req, data_wr, mem_valid, mem_valid_ready_go, mem_excp, mem_load_pending;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata, mem_out_value, mem_pc, mem_badvaddr;
  logic [OP_W-1:0] mem_out_op;
  logic [RF_AW-1:0] mem_rf_waddr;
  logic [4:0] mem_excp_code;
  logic mem_allowin2, data_req2, data_wr2, mem_valid2, mem_valid_ready_go2, mem_excp2, mem_load_pending2;
  logic [1:0] data_size2;
  logic [3:0] data_wstrb2;
  logic [31:0] data_addr2, data_wdata2, mem_out_value2, mem_pc2, mem_badvaddr2;
  logic [OP_W-1:0] mem_out_op2;
  logic [RF_AW-1:0] mem_rf_waddr2;
  logic [4:0] mem_excp_code2;
  int n_cmp = 0, n_bad = 0;
  logic bus_out = 1'b0;
  logic mv = 1'b0, m_rp = 1'b0, m_dp = 1'b0, m_e = 1'b0;
  logic [3:0] m_c = '0;
  logic [31:0] m_a = '0, m_rt = '0, m_pc = '0, m_d = '0;
  logic [OP_W-1:0] m_op = '0;
  logic [RF_AW-1:0] m_wa = '0;
  logic [3:0] lc [3] = '{4'd1, 4'd2, 4'd3};
  logic [31:0] la [3] = '{32'h103, 32'h103, 32'h102};
  logic [31:0] lv [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};

  always #5 clk = ~clk;

  mips_mem_stage_hs #(.OP_W(OP_W), .RF_AW(RF_AW)) dut (
    .clk(clk), .rst(rst), .ex_valid_ready_go(ex_valid_ready_go), .mem_allowin(mem_allowin),
    .ex_op(ex_op), .ex_mem_ctrl(ex_mem_ctrl), .ex_rf_waddr(ex_rf_waddr), .ex_addr(ex_addr),
    .ex_rt_data(ex_rt_data), .ex_pc(ex_pc), .flush(flush), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_valid(mem_valid), .mem_valid_ready_go(mem_valid_ready_go), .wb_allowin(wb_allowin),
    .mem_out_op(mem_out_op), .mem_rf_waddr(mem_rf_waddr), .mem_out_value(mem_out_value),
    .mem_pc(mem_pc), .mem_excp(mem_excp), .mem_excp_code(mem_excp_code),
    .mem_badvaddr(mem_badvaddr), .mem_load_pending(mem_load_pending));

  mips_mem_stage_hs #(.OP_W(OP_W), .RF_AW(RF_AW), .ADDR_CHECK(1'b0)) dut_nochk (
    .clk(clk), .rst(rst), .ex_valid_ready_go(ex_valid_ready_go), .mem_allowin(mem_allowin2),
    .ex_op(ex_op), .ex_mem_ctrl(ex_mem_ctrl), .ex_rf_waddr(ex_rf_waddr), .ex_addr(ex_addr),
    .ex_rt_data(ex_rt_data), .ex_pc(ex_pc), .flush(flush), .data_req(data_req2), .data_wr(data_wr2),
    .data_size(data_size2), .data_addr(data_addr2), .data_wstrb(data_wstrb2), .data_wdata(data_wdata2),
    .data_addr_ok(1'b0), .data_data_ok(1'b0), .data_rdata(32'd0),
    .mem_valid(mem_valid2), .mem_valid_ready_go(mem_valid_ready_go2), .wb_allowin(wb_allowin),
    .mem_out_op(mem_out_op2), .mem_rf_waddr(mem_rf_waddr2), .mem_out_value(mem_out_value2),
    .mem_pc(mem_pc2), .mem_excp(mem_excp2), .mem_excp_code(mem_excp_code2),
    .mem_badvaddr(mem_badvaddr2), .mem_load_pending(mem_load_pending2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_norm(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: return c;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic m_err(input logic [3:0] c, input logic [31:0] a);
    if (c == 4'd3 || c == 4'd4 || c == 4'd10) return a[0];
    if (c == 4'd5 || c == 4'd11) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_size(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd9: return 2'd0;
      4'd3, 4'd4, 4'd10: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] c, input logic [31:0] a);
    logic [15:0] t_sb, t_swl, t_swr;
    int s;
    t_sb = 16'b1000_0100_0010_0001;
    t_swl = 16'b1111_0111_0011_0001;
    t_swr = 16'b1000_1100_1110_1111;
    s = int'(a[1:0]);
    case (c)
      4'd9: return t_sb[4*s +: 4];
      4'd10: return a[1] ? 4'b1100 : 4'b0011;
      4'd11: return 4'b1111;
      4'd12: return t_swl[4*s +: 4];
      4'd13: return t_swr[4*s +: 4];
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] c, input logic [31:0] a, input logic [31:0] rt);
    logic [31:0] w;
    int s;
    w = '0;
    s = int'(a[1:0]);
    for (int k = 0; k < 4; k++)
      case (c)
        4'd9: w[8*k +: 8] = rt[7:0];
        4'd10: w[8*k +: 8] = rt[8*(k%2) +: 8];
        4'd11: w[8*k +: 8] = rt[8*k +: 8];
        4'd12: if (k <= s) w[8*k +: 8] = rt[8*(k+3-s) +: 8];
        4'd13: if (k >= s) w[8*k +: 8] = rt[8*(k-s) +: 8];
        default: ;
      endcase
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] rt, input logic [31:0] d);
    logic [31:0] r;
    int s, h;
    r = rt;
    s = int'(a[1:0]);
    h = a[1] ? 16 : 0;
    case (c)
      4'd1: r = {{24{d[8*s+7]}}, d[8*s +: 8]};
      4'd2: r = {24'd0, d[8*s +: 8]};
      4'd3: r = {{16{d[h+15]}}, d[h +: 16]};
      4'd4: r = {16'd0, d[h +: 16]};
      4'd5: r = d;
      4'd6: for (int k = 0; k < 4; k++) if (k >= 3 - s) r[8*k +: 8] = d[8*(k-3+s) +: 8];
      4'd7: for (int k = 0; k < 4; k++) if (k <= 3 - s) r[8*k +: 8] = d[8*(k+s) +: 8];
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic m_allow();
    return !m_rp && !m_dp && (!mv || wb_allowin);
  endfunction

  // Bus responder bookkeeping: one accepted request outstanding until its data_ok
  always @(posedge clk)
    if (rst) bus_out <= 1'b0;
    else if (data_req && data_addr_ok) bus_out <= 1'b1;
    else if (data_data_ok) bus_out <= 1'b0;

  // Reference model: instruction held in MEM plus pending request / pending response flags
  always @(posedge clk) begin
    logic al;
    if (rst) begin
      mv = 1'b0; m_rp = 1'b0; m_dp = 1'b0; m_e = 1'b0; m_c = '0; m_a = '0; m_rt = '0;
      m_pc = '0; m_d = '0; m_op = '0; m_wa = '0;
    end else begin
      al = m_allow();
      if (m_rp && data_addr_ok) begin
        m_rp = 1'b0;
        m_dp = 1'b1;
      end else if (m_dp && data_data_ok) begin
        m_dp = 1'b0;
        m_d = data_rdata;
      end
      if (flush) mv = 1'b0;
      else if (al) begin
        mv = ex_valid_ready_go;
        if (ex_valid_ready_go) begin
          m_c = m_norm(ex_mem_ctrl); m_a = ex_addr; m_rt = ex_rt_data; m_pc = ex_pc;
          m_op = ex_op; m_wa = ex_rf_waddr;
          m_e = m_c != 4'd0 && m_err(m_c, ex_addr);
          m_rp = m_c != 4'd0 && !m_e;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    logic rdy, ld, st;
    if (!rst) begin
      rdy = mv && !m_rp && !m_dp;
      ld = m_c != 4'd0 && m_c <= 4'd7;
      st = m_c >= 4'd9;
      chk("mem_valid", 32'(mem_valid), 32'(mv));
      chk("mem_allowin", 32'(mem_allowin), 32'(m_allow()));
      chk("data_req", 32'(data_req), 32'(m_rp));
      chk("ready_go", 32'(mem_valid_ready_go), 32'(rdy));
      chk("load_pending", 32'(mem_load_pending), 32'(mv && ld && !rdy));
      chk("mem_excp", 32'(mem_excp), 32'(mv && m_e));
      if (m_rp) begin
        chk("data_wr", 32'(data_wr), 32'(st));
        chk("data_size", 32'(data_size), 32'(m_size(m_c)));
        chk("data_addr", data_addr, (m_c == 4'd6 || m_c == 4'd7 || m_c == 4'd12 || m_c == 4'd13) ? {m_a[31:2], 2'b00} : m_a);
        chk("data_wstrb", 32'(data_wstrb), 32'(m_strb(m_c, m_a)));
        if (st) chk("data_wdata", data_wdata, m_wdata(m_c, m_a, m_rt));
      end
      if (mv) begin
        chk("mem_out_op", mem_out_op, m_op);
        chk("mem_rf_waddr", 32'(mem_rf_waddr), 32'(m_wa));
        chk("mem_pc", mem_pc, m_pc);
        if (m_e) begin
          chk("excp_code", 32'(mem_excp_code), st ? 32'd5 : 32'd4);
          chk("badvaddr", mem_badvaddr, m_a);
        end else if (rdy) chk("out_value", mem_out_value, ld ? m_load(m_c, m_a, m_rt, m_d) : m_a);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] rt);
    ex_valid_ready_go = 1'b1; ex_mem_ctrl = c; ex_addr = a; ex_rt_data = rt;
    ex_op = $urandom; ex_rf_waddr = RF_AW'($urandom); ex_pc = $urandom;
    step();
    ex_valid_ready_go = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] rd);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
    step();
    data_data_ok = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    #2;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_excp", 32'(mem_excp), 32'd0);
    chk("rst_allowin", 32'(mem_allowin), 32'd1);
    rst = 1'b0;
    step();
    issue(4'd3, 32'h201, 32'd0);
    #2;
    chk("ade_req", 32'(data_req), 32'd0);
    chk("ade_excp", 32'(mem_excp), 32'd1);
    chk("ade_code", 32'(mem_excp_code), 32'd4);
    chk("ade_badv", mem_badvaddr, 32'h201);
    chk("ade_rdy", 32'(mem_valid_ready_go), 32'd1);
    chk("nochk_req", 32'(data_req2), 32'd1);
    step();
    issue(4'd5, 32'h100, 32'd0);
    data_addr_ok = 1'b1;
    #2;
    chk("lw_req", 32'(data_req), 32'd1);
    chk("lw_addr", data_addr, 32'h100);
    chk("lw_rdy_e", 32'(mem_valid_ready_go), 32'd0);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #2;
    chk("lw_rdy_e1", 32'(mem_valid_ready_go), 32'd0);
    step();
    data_data_ok = 1'b0;
    #2;
    chk("lw_rdy_e2", 32'(mem_valid_ready_go), 32'd1);
    chk("lw_val", mem_out_value, 32'hDEAD_BEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      issue(lc[i], la[i], 32'd0);
      xfer(32'h80FF_7F01);
      #2;
      chk("ld_val", mem_out_value, lv[i]);
      step();
    end
    issue(4'd12, 32'h301, 32'h1122_3344);
    #2;
    chk("swl_strb", 32'(data_wstrb), 32'b0011);
    chk("swl_wdata", data_wdata, 32'h0000_1122);
    chk("swl_addr", data_addr, 32'h300);
    chk("swl_size", 32'(data_size), 32'd2);
    xfer(32'd0);
    step();
    issue(4'd10, 32'h302, 32'hAABB_CCDD);
    #2;
    chk("sh_strb", 32'(data_wstrb), 32'b1100);
    chk("sh_wdata", data_wdata, 32'hCCDD_CCDD);
    xfer(32'd0);
    step();
    issue(4'd5, 32'h400, 32'd0);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #2;
      chk("drop_valid", 32'(mem_valid), 32'd0);
      chk("drop_allowin", 32'(mem_allowin), 32'd0);
      step();
    end
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    #2;
    chk("drop_allowin_ok", 32'(mem_allowin), 32'd0);
    step();
    data_data_ok = 1'b0;
    #2;
    chk("drop_after", 32'(mem_allowin), 32'd1);
    issue(4'd0, 32'h55, 32'd0);
    #2;
    chk("post_drop_val", mem_out_value, 32'h55);
    chk("post_drop_rdy", 32'(mem_valid_ready_go), 32'd1);
    step();
    issue(4'd11, 32'h500, 32'hCAFE_F00D);
    wb_allowin = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #2;
      chk("hold_req", 32'(data_req), 32'd1);
      chk("hold_addr", data_addr, 32'h500);
      chk("hold_wdata", data_wdata, 32'hCAFE_F00D);
      step();
    end
    xfer(32'd0);
    for (int j = 0; j < 3; j++) begin
      #2;
      chk("done_rdy", 32'(mem_valid_ready_go), 32'd1);
      chk("done_val", mem_out_value, 32'h500);
      chk("done_noreq", 32'(data_req), 32'd0);
      step();
    end
    wb_allowin = 1'b1;
    step();
    for (int i = 0; i < 4000; i++) begin
      ex_valid_ready_go = ($urandom % 4) != 0;
      ex_mem_ctrl = 4'($urandom);
      ex_addr = $urandom; ex_rt_data = $urandom; ex_pc = $urandom;
      ex_op = $urandom; ex_rf_waddr = RF_AW'($urandom);
      flush = ($urandom % 20) == 0;
      wb_allowin = ($urandom % 4) != 0;
      data_addr_ok = data_req && !bus_out && ($urandom % 2 == 0);
      data_data_ok = bus_out && ($urandom % 2 == 0);
      data_rdata = $urandom;
      step();
    end
    ex_valid_ready_go = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_mem_stage_hs.md
Name: mips_mem_stage_hs

Overview:
Parametrised next-generation MIPS MEM stage that issues its own data-memory access through a variable-latency req/addr_ok/data_ok bus, rather than depending on fixed one-cycle SRAM read data. It generates store strobes and data, extracts and merges load data (LB/LBU/LH/LHU/LW/LWL/LWR), and detects address errors. A flush cancels the in-flight instruction safely, including any outstanding bus transaction. It sits between the EX and WB stages and uses the same valid/allowin/ready_go pipeline handshake.

Parameters:
OP_W, 32, width of the opaque control bundle passed through to WB
RF_AW, 5, register-file write-address width
HAS_UNALIGNED, 1, 1 = support LWL/LWR/SWL/SWR; 0 = those codes behave as non-memory ops
ADDR_CHECK, 1, 1 = detect AdEL/AdES; 0 = never raise an exception

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex_valid_ready_go  in  1  EX holds a valid instruction that is ready to move
mem_allowin  out  1  MEM accepts a new instruction this cycle
ex_op  in  OP_W  control bundle, passthrough
ex_mem_ctrl  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 9 SB, 10 SH, 11 SW, 12 SWL, 13 SWR; any other code = none
ex_rf_waddr  in  RF_AW  destination register
ex_addr  in  32  ALU result / effective address
ex_rt_data  in  32  rt value (store data, LWL/LWR merge source)
ex_pc  in  32  PC
flush  in  1  exception/eret flush from WB
data_req  out  1  bus request
data_wr  out  1  1 = store
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  32  bus address
data_wstrb  out  4  byte strobes
data_wdata  out  32  store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data / write response returned
data_rdata  in  32  read data
mem_valid  out  1  MEM holds a valid instruction
mem_valid_ready_go  out  1  MEM result is ready for WB
wb_allowin  in  1  WB accepts an instruction
mem_out_op  out  OP_W  latched ex_op
mem_rf_waddr  out  RF_AW  latched destination
mem_out_value  out  32  final result
mem_pc  out  32  latched PC
mem_excp  out  1  address error
mem_excp_code  out  5  4 = AdEL, 5 = AdES
mem_badvaddr  out  32  faulting address
mem_load_pending  out  1  mem_valid and load and not ready_go (bypass must stall)

Behaviour:
- Reset: state IDLE; mem_valid, data_req, mem_excp = 0; all latched registers = 0.
- Accept when ex_valid_ready_go && mem_allowin && !flush: latch all ex_* inputs; mem_valid <= 1. If the op is a memory op and there is no address error, state <= REQ; otherwise state <= IDLE.
- mem_valid update: mem_valid <= 0 on flush; else, if mem_allowin, mem_valid <= ex_valid_ready_go.
- FSM states: IDLE, REQ, WAIT, DONE, DROP_REQ, DROP_DATA.
  - REQ: data_req = 1; address, size, strobe and data held stable. On addr_ok -> WAIT.
  - WAIT: on data_ok -> capture data_rdata -> DONE.
  - DONE, or IDLE with mem_valid: ready_go = 1. Leave to REQ/IDLE when WB accepts.
- Bus rule: data_ok arrives at least one cycle after its addr_ok; at most one transaction is outstanding.
- Minimum access latency: accepted at edge E; req/addr_ok in cycle E; data_ok in E+1; ready_go in E+2.
- Flush:
  - REQ & !addr_ok -> DROP_REQ, which keeps data_req until addr_ok.
  - REQ & addr_ok -> DROP_DATA.
  - WAIT & !data_ok -> DROP_DATA.
  - WAIT & data_ok, or DONE -> IDLE.
  - DROP_REQ: on addr_ok -> DROP_DATA. DROP_DATA: on data_ok -> IDLE, data discarded.
- mem_allowin = !DROP_* && (!mem_valid || ready_go && wb_allowin).
- Strobes:
  - SB: 0001 << a[1:0]. SH: a[1] ? 1100 : 0011. SW: 1111.
  - SWL: a = 0,1,2,3 -> 0001, 0011, 0111, 1111.
  - SWR: a = 0,1,2,3 -> 1111, 1110, 1100, 1000.
- Store data: SB {4{rt[7:0]}}; SH {2{rt[15:0]}}; SW rt; SWL rt >> 8*(3-a); SWR rt << 8*a.
- Size: byte ops 0, half ops 1, all others 2. Loads use strobe 0000.
- Address: LWL/LWR/SWL/SWR use {a[31:2], 2'b00}; all others use ex_addr.
- Address errors (ADDR_CHECK = 1):
  - Half op with a[0] != 0, or LW/SW with a[1:0] != 0, raises the exception.
  - No request is issued; mem_excp = 1; code 4 for loads, 5 for stores; badvaddr = address; ready_go is immediate.
- Load result (byte lane = a):
  - LB/LBU: lane a, sign- or zero-extended. LH/LHU: half a[1], sign- or zero-extended. LW: full word.
  - LWL: a=0 {d[7:0], rt[23:0]}; a=1 {d[15:0], rt[15:0]}; a=2 {d[23:0], rt[7:0]}; a=3 d.
  - LWR: a=0 d; a=1 {rt[31:24], d[31:8]}; a=2 {rt[31:16], d[31:16]}; a=3 {rt[31:8], d[31:24]}.
  - Stores and non-memory ops: mem_out_value = latched ex_addr.
- Reset in the middle of a transaction returns the FSM to IDLE; the bus is reset together with this block.

Test Plan:
- LW 0x100, addr_ok same cycle, data_ok +1 with 0xDEADBEEF -> mem_out_value 0xDEADBEEF, ready_go 2 cycles after accept.
- LB/LBU/LH at 0x103 / 0x102, rdata 0x80FF7F01 -> LB 0xFFFFFF80, LBU 0x00000080, LH 0xFFFF80FF.
- SWL a=1, rt 0x11223344 -> wstrb 0011, wdata 0x00001122, addr 0x...0, size 2. SH a=2 -> wstrb 1100.
- LH at 0x201 -> no data_req, mem_excp 1, code 4, badvaddr 0x201. With ADDR_CHECK=0 -> request issued.
- flush during WAIT, data_ok 3 cycles later -> mem_valid 0, mem_allowin 0 until data_ok, data discarded, next instruction accepted after.
- addr_ok withheld 4 cycles, with wb_allowin 0 in DONE -> data_req and address stable throughout; result held; no second request.
